// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared defaults and the prefetch-queue entry layout for the fetch stage.
// Entries are packed as {instr, pcplus4}, with the instruction in the upper half.
package fetch_prefetch_unit_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam int          PC_STEP_DEF  = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0;

   typedef struct packed {
      logic [XLEN_DEF-1:0] instr;
      logic [XLEN_DEF-1:0] pcplus4;
   } fetch_entry_t;

   // Index width that stays legal when only one slot exists.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fetch_queue.sv
// Synchronous FIFO for the prefetch queue.
// Reset zeroes the storage, so the head reads as zero until the first push.
module fetch_queue
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int W     = 2 * XLEN_DEF,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a variable-latency
// memory and hands buffered words to decode through a small prefetch queue.
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int              PC_STEP  = PC_STEP_DEF
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            PCsrc,
   input  logic [XLEN-1:0] pcBranch,
   input  logic            stallD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            validD,
   output logic [XLEN-1:0] instructionD,
   output logic [XLEN-1:0] pcplus4D
);

   localparam int              OW   = $clog2(MAX_OUT + 1);
   localparam int              TW   = clog2_min1(MAX_OUT);
   localparam int              CW   = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   logic [XLEN-1:0]   pc;
   logic [OW-1:0]     outstanding;
   logic [OW-1:0]     discard;
   logic [XLEN-1:0]   tags [MAX_OUT];
   logic [TW-1:0]     tag_wr;
   logic [TW-1:0]     tag_rd;
   logic [CW-1:0]     count;
   logic              empty;
   logic [2*XLEN-1:0] head;
   logic              accept;
   logic              push;
   logic              pop;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      return (int'(p) == MAX_OUT - 1) ? '0 : p + TW'(1);
   endfunction

   // Queue slots are reserved at issue time, so a response can never find the queue full.
   assign imem_req  = !reset && !PCsrc && (int'(outstanding) < MAX_OUT) &&
                      (int'(outstanding) + int'(count) < DEPTH);
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign push      = imem_rvalid && (discard == '0) && !PCsrc;
   assign pop       = !empty && !stallD && !PCsrc;

   always_ff @(posedge CLK) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         if (PCsrc)       pc <= pcBranch;
         else if (accept) pc <= pc + STEP;
         outstanding <= outstanding + OW'(accept) - OW'(imem_rvalid);
         // Everything still in flight at a redirect belongs to the old path.
         if (PCsrc)                             discard <= outstanding - OW'(imem_rvalid);
         else if (imem_rvalid && discard != '0) discard <= discard - OW'(1);
         if (accept)      tag_wr <= tag_next(tag_wr);
         if (imem_rvalid) tag_rd <= tag_next(tag_rd);
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) tags[tag_wr] <= pc;
   end

   fetch_queue #(
      .W     (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (CLK),
      .rst   (reset),
      .flush (PCsrc),
      .push  (push),
      .pop   (pop),
      .wdata ({imem_rdata, tags[tag_rd] + STEP}),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

   assign validD       = !empty;
   assign instructionD = head[2*XLEN-1:XLEN];
   assign pcplus4D     = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit with a queue-level reference model and an
// in-order variable-latency memory model.
module tb_fetch_prefetch_unit;

   localparam int          XLEN    = 32;
   localparam int          DEPTH   = 4;
   localparam int          MAX_OUT = 2;
   localparam logic [31:0] RPC     = 32'hFFFF_FFF8;
   localparam int          STEP    = 4;

   logic            CLK = 1'b0;
   logic            reset = 1'b1;
   logic            PCsrc = 1'b0;
   logic [XLEN-1:0] pcBranch = '0;
   logic            stallD = 1'b0;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready = 1'b0;
   logic            imem_rvalid = 1'b0;
   logic [XLEN-1:0] imem_rdata = '0;
   logic            validD;
   logic [XLEN-1:0] instructionD;
   logic [XLEN-1:0] pcplus4D;

   always #5 CLK = ~CLK;

   fetch_prefetch_unit #(
      .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC), .PC_STEP(STEP)
   ) dut (
      .CLK(CLK), .reset(reset), .PCsrc(PCsrc), .pcBranch(pcBranch), .stallD(stallD),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .validD(validD), .instructionD(instructionD), .pcplus4D(pcplus4D)
   );

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   // Reference model: decode queue of {instr, pcplus4}, issued-address list, counters.
   logic [31:0] m_pc = RPC;
   logic [63:0] m_q[$];
   logic [31:0] m_tags[$];
   int          m_out  = 0;
   int          m_disc = 0;

   // Memory model: pending addresses with the cycle each response is due.
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic r, input logic pcs, input logic [31:0] br,
                       input logic st, input logic rdy, input int lat);
      logic        rv;
      logic [31:0] rd;
      logic [31:0] tag;
      logic        e_req;
      int          out_old;
      int          due;
      @(negedge CLK);
      reset = r; PCsrc = pcs; pcBranch = br; stallD = st; imem_ready = rdy;
      rv = !r && (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
      rd = rv ? memdata(mem_addr_q[0]) : $urandom;
      imem_rvalid = rv; imem_rdata = rd;
      #1;
      e_req = !r && !pcs && (m_out < MAX_OUT) && (m_out + m_q.size() < DEPTH);
      check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
      if (!r) check("imem_addr", imem_addr, m_pc);
      check("validD", {31'd0, validD}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
         check("instructionD", instructionD, m_q[0][63:32]);
         check("pcplus4D", pcplus4D, m_q[0][31:0]);
      end
      if (r) begin
         m_pc = RPC; m_q.delete(); m_tags.delete(); m_out = 0; m_disc = 0;
         mem_addr_q.delete(); mem_due_q.delete();
      end else begin
         out_old = m_out;
         tag = 32'd0;
         if (rv) begin
            if (m_tags.size() > 0) tag = m_tags.pop_front();
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
            m_out--;
         end
         if (pcs) begin
            m_q.delete();
            m_disc = out_old - (rv ? 1 : 0);
            m_pc = br;
         end else begin
            if (m_q.size() > 0 && !st) void'(m_q.pop_front());
            if (rv) begin
               if (m_disc > 0) m_disc--;
               else m_q.push_back({rd, tag + 32'(STEP)});
            end
         end
         if (e_req && rdy) begin
            due = cyc + lat;
            if (mem_due_q.size() > 0 && mem_due_q[$] + 1 > due) due = mem_due_q[$] + 1;
            mem_addr_q.push_back(m_pc);
            mem_due_q.push_back(due);
            m_tags.push_back(m_pc);
            m_out++;
            m_pc = m_pc + 32'(STEP);
         end
      end
      cyc++;
   endtask

   initial begin
      bit done;
      bit found;

      repeat (3) step(1, 0, 0, 0, 1, 1);
      check("rst_validD", {31'd0, validD}, 32'd0);
      check("rst_instr", instructionD, 32'd0);
      check("rst_pcplus4", pcplus4D, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);

      // Streaming from the reset PC, across the 32-bit wrap.
      for (int c = 0; c < 20; c++) begin
         step(0, 0, 0, 0, 1, 1);
         if (c == 0) begin
            check("lit_addr0", imem_addr, 32'hFFFF_FFF8);
            check("lit_valid0", {31'd0, validD}, 32'd0);
         end
         if (c == 1) check("lit_addr1", imem_addr, 32'hFFFF_FFFC);
         if (c == 2) begin
            check("lit_addr2", imem_addr, 32'h0000_0000);
            check("lit_valid2", {31'd0, validD}, 32'd1);
            check("lit_pc4_2", pcplus4D, 32'hFFFF_FFFC);
            check("lit_instr2", instructionD, memdata(32'hFFFF_FFF8));
         end
         if (c == 3) check("lit_pc4_3", pcplus4D, 32'h0000_0000);
         if (c == 4) check("lit_pc4_4", pcplus4D, 32'h0000_0004);
      end

      // Decode stall fills the queue, then drains.
      for (int c = 0; c < 10; c++) step(0, 0, 0, 1, 1, 1);
      check("stall_req_low", {31'd0, imem_req}, 32'd0);
      check("stall_valid", {31'd0, validD}, 32'd1);
      for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 1, 1);

      // Three-cycle memory.
      for (int c = 0; c < 30; c++) step(0, 0, 0, 0, 1, 3);

      // Redirect with two requests in flight.
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (m_out == 2) begin
            step(0, 1, 32'h100, 0, 1, 3);
            done = 1;
         end else begin
            step(0, 0, 0, 0, 1, 3);
         end
      end
      vectors++;
      if (!done) begin
         errors++;
         $display("FAIL redirect_setup: got no cycle with 2 outstanding, required one");
      end
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 0, 0, 0, 1, 1);
         if (validD) begin
            found = 1;
            check("redir_pcplus4", pcplus4D, 32'h104);
            check("redir_instr", instructionD, memdata(32'h100));
         end
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL redirect_timeout: got no validD in 20 cycles, required one");
      end

      // Random traffic: ready, latency, stall, redirects and occasional reset.
      for (int c = 0; c < 2000; c++) begin
         step(($urandom_range(99) == 0), ($urandom_range(99) < 8),
              $urandom & 32'hFFFF_FFFC, ($urandom_range(99) < 30),
              ($urandom_range(99) < 75), int'($urandom_range(3, 1)));
      end

      // Reset in the middle of a stream.
      step(1, 0, 0, 0, 1, 1);
      for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      check("midrst_valid", {31'd0, validD}, 32'd0);
      check("midrst_addr", imem_addr, 32'hFFFF_FFF8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
